// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: funct3 codes, widths and the multiply/divide FSM state encoding.
package rv32m_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage M-extension request/result bundle between the pipeline and the multiply/divide unit.
interface ex_muldiv_unit_if
    import rv32m_pkg::*;
;
    logic            start_i;
    logic            kill_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic [4:0]      rd_i;
    logic            stall_o;
    logic            busy_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_o;

    modport master (
        output start_i, kill_i, op_i, a_i, b_i, rd_i,
        input  stall_o, busy_o, valid_o, result_o, rd_o
    );

    modport slave (
        input  start_i, kill_i, op_i, a_i, b_i, rd_i,
        output stall_o, busy_o, valid_o, result_o, rd_o
    );
endinterface

// File: rtl/muldiv_operand_prep.sv
// Combinational operand conditioning: magnitudes, result sign, and divide special-case results.
module muldiv_operand_prep
    import rv32m_pkg::*;
(
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] a_mag_o,
    output logic [XLEN-1:0] b_mag_o,
    output logic            neg_o,
    output logic            is_div_o,
    output logic            special_o,
    output logic [XLEN-1:0] special_res_o
);

    logic a_signed, b_signed, a_neg, b_neg, is_rem, div_zero, div_ovf;

    assign a_signed = (op_i == F3_MULH) || (op_i == F3_MULHSU) || (op_i == F3_DIV) || (op_i == F3_REM);
    assign b_signed = (op_i == F3_MULH) || (op_i == F3_DIV) || (op_i == F3_REM);
    assign a_neg    = a_signed && a_i[XLEN-1];
    assign b_neg    = b_signed && b_i[XLEN-1];
    assign is_div_o = op_i[2];
    assign is_rem   = op_i[1];

    assign a_mag_o = a_neg ? (~a_i + XLEN'(1)) : a_i;
    assign b_mag_o = b_neg ? (~b_i + XLEN'(1)) : b_i;

    // Multiplies negate on mixed signs; signed divide follows the quotient/remainder sign rules
    always_comb begin
        neg_o = 1'b0;
        case (op_i)
            F3_DIV:  neg_o = a_i[XLEN-1] ^ b_i[XLEN-1];
            F3_REM:  neg_o = a_i[XLEN-1];
            F3_DIVU,
            F3_REMU: neg_o = 1'b0;
            default: neg_o = a_neg ^ b_neg;
        endcase
    end

    assign div_zero = is_div_o && (b_i == '0);
    assign div_ovf  = ((op_i == F3_DIV) || (op_i == F3_REM)) &&
                      (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
    assign special_o = div_zero || div_ovf;

    always_comb begin
        special_res_o = '0;
        if (div_zero) begin
            special_res_o = is_rem ? a_i : '1;
        end else if (div_ovf) begin
            special_res_o = is_rem ? '0 : a_i;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit: 32 CALC steps, then sign fix-up and a one-cycle result.
module ex_muldiv_unit
    import rv32m_pkg::*;
(
    input  logic             clk,
    input  logic             clrn,
    ex_muldiv_unit_if.slave  bus
);

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [4:0]      rd_q, rd_d, rd_out_q, rd_out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d, res_q, res_d;
    logic            neg_q, neg_d, valid_q, valid_d;

    logic [XLEN-1:0] a_mag, b_mag, special_res;
    logic            neg_c, is_div_c, special_c;

    muldiv_operand_prep u_prep (
        .op_i          (bus.op_i),
        .a_i           (bus.a_i),
        .b_i           (bus.b_i),
        .a_mag_o       (a_mag),
        .b_mag_o       (b_mag),
        .neg_o         (neg_c),
        .is_div_o      (is_div_c),
        .special_o     (special_c),
        .special_res_o (special_res)
    );

    // hi/lo hold {product high, multiplier} for multiplies and {remainder, dividend/quotient} for divides
    logic [XLEN:0]     mul_sum, div_shift;
    logic [XLEN+1:0]   div_diff;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fin_res;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    assign prod_s    = neg_q ? (~{hi_q, lo_q} + (2*XLEN)'(1)) : {hi_q, lo_q};
    assign quo_s     = neg_q ? (~lo_q + XLEN'(1)) : lo_q;
    assign rem_s     = neg_q ? (~hi_q + XLEN'(1)) : hi_q;

    always_comb begin
        fin_res = '0;
        case (op_q)
            F3_MUL:                      fin_res = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fin_res = prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:             fin_res = quo_s;
            default:                     fin_res = rem_s;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rd_d        = rd_q;
        rd_out_d    = rd_out_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        opnd_d      = opnd_q;
        res_d       = res_q;
        neg_d       = neg_q;
        valid_d     = 1'b0;
        bus.stall_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start_i && !bus.kill_i) begin
                    bus.stall_o = 1'b1;
                    op_d        = bus.op_i;
                    rd_d        = bus.rd_i;
                    neg_d       = neg_c;
                    hi_d        = '0;
                    lo_d        = is_div_c ? a_mag : b_mag;
                    opnd_d      = is_div_c ? b_mag : a_mag;
                    if (special_c) begin
                        state_d  = DONE;
                        res_d    = special_res;
                        rd_out_d = bus.rd_i;
                        valid_d  = 1'b1;
                    end else begin
                        state_d = CALC;
                        cnt_d   = CNT_W'(XLEN - 1);
                    end
                end
            end
            CALC: begin
                bus.stall_o = 1'b1;
                if (op_q[2]) begin
                    hi_d = div_diff[XLEN+1] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], ~div_diff[XLEN+1]};
                end else begin
                    hi_d = mul_sum[XLEN:1];
                    lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                bus.stall_o = 1'b1;
                res_d       = fin_res;
                rd_out_d    = rd_q;
                valid_d     = 1'b1;
                state_d     = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush discards the operation and leaves the last published result untouched
        if (bus.kill_i) begin
            state_d  = IDLE;
            valid_d  = 1'b0;
            res_d    = res_q;
            rd_out_d = rd_out_q;
        end
    end

    always_ff @(posedge clk) begin
        if (clrn) begin
            state_q  <= IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            rd_out_q <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            res_q    <= '0;
            neg_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rd_out_q <= rd_out_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            res_q    <= res_d;
            neg_q    <= neg_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.busy_o   = (state_q != IDLE);
    assign bus.valid_o  = valid_q;
    assign bus.result_o = res_q;
    assign bus.rd_o     = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: latency, stall, kill and reset behaviour plus result values.
module tb_ex_muldiv_unit;
    import rv32m_pkg::*;

    logic clk = 1'b0;
    logic clrn;
    always #5 clk = ~clk;

    ex_muldiv_unit_if bus ();
    ex_muldiv_unit dut (.clk(clk), .clrn(clrn), .bus(bus));

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] res;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_res = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int          si, sj;
        logic        ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        si  = a;
        sj  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(si / sj);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(si % sj);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Called at a negedge with the unit idle; leaves it idle at a negedge.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int lat, input bit hold);
        exp_t e;
        sb_q.push_back({rd, exp});
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        bus.rd_i    = rd;
        #1 chk("stall_c0", 32'(bus.stall_o), 1);
        @(posedge clk);
        #1 if (!hold) bus.start_i = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c < lat) begin
                chk("valid_early", 32'(bus.valid_o), 0);
                chk("stall_busy", 32'(bus.stall_o), 1);
            end else begin
                chk("valid_done", 32'(bus.valid_o), 1);
                chk("stall_done", 32'(bus.stall_o), 0);
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("result", bus.result_o, e.res);
                    chk("rd", 32'(bus.rd_o), 32'(e.rd));
                    last_res = e.res;
                end
            end
        end
        bus.start_i = 1'b0;
        @(negedge clk);
        chk("valid_once", 32'(bus.valid_o), 0);
        chk("idle_after", 32'(bus.busy_o), 0);
        chk("result_hold", bus.result_o, last_res);
    endtask

    function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0)) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        clrn        = 1'b1;
        bus.start_i = 1'b0;
        bus.kill_i  = 1'b0;
        bus.op_i    = '0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        bus.rd_i    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(bus.valid_o), 0);
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_result", bus.result_o, 0);
        chk("rst_rd", 32'(bus.rd_o), 0);
        chk("rst_stall", 32'(bus.stall_o), 0);
        clrn = 1'b0;
        @(negedge clk);

        run_op(F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 34, 1'b0);

        run_op(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 34, 1'b0);
        run_op(F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0000, 34, 1'b0);
        run_op(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 34, 1'b0);
        run_op(F3_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'h0000_0001, 34, 1'b0);

        run_op(F3_DIV,  32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 34, 1'b0);
        run_op(F3_REM,  32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 34, 1'b0);
        run_op(F3_DIVU, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'h7FFF_FFFC, 34, 1'b0);
        run_op(F3_REMU, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'h0000_0001, 34, 1'b0);

        run_op(F3_DIV,  32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, 1, 1'b0);
        run_op(F3_REMU, 32'd5, 32'd0, 5'd11, 32'd5, 1, 1'b0);
        run_op(F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1, 1'b0);
        run_op(F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd0,  32'h0, 1, 1'b0);

        // Kill a DIVU mid-flight, then start a MUL in the very next cycle
        bus.start_i = 1'b1;
        bus.op_i    = F3_DIVU;
        bus.a_i     = 32'd100;
        bus.b_i     = 32'd7;
        bus.rd_i    = 5'd13;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            chk("kill_no_valid", 32'(bus.valid_o), 0);
            if (c == 10) bus.kill_i = 1'b1;
        end
        @(posedge clk);
        #1 bus.kill_i = 1'b0;
        @(negedge clk);
        chk("kill_idle", 32'(bus.busy_o), 0);
        chk("kill_valid", 32'(bus.valid_o), 0);
        chk("kill_result_hold", bus.result_o, last_res);
        run_op(F3_MUL, 32'd3, 32'd4, 5'd14, 32'd12, 34, 1'b0);

        // start_i held high throughout must not retrigger
        run_op(F3_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 5'd15,
               ref_res(F3_MULHU, 32'hDEAD_BEEF, 32'h1234_5678), 34, 1'b1);

        // Synchronous reset in the middle of an operation
        bus.start_i = 1'b1;
        bus.op_i    = F3_MULHU;
        bus.a_i     = 32'hFFFF_FFFF;
        bus.b_i     = 32'hFFFF_FFFF;
        bus.rd_i    = 5'd17;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            chk("rst_mid_no_valid", 32'(bus.valid_o), 0);
            if (c == 20) begin
                clrn        = 1'b1;
                bus.start_i = 1'b0;
            end
        end
        @(posedge clk);
        #1 clrn = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 32'(bus.busy_o), 0);
        chk("rst_mid_valid", 32'(bus.valid_o), 0);
        chk("rst_mid_result", bus.result_o, 0);
        chk("rst_mid_rd", 32'(bus.rd_o), 0);
        last_res = '0;

        for (int i = 0; i < 10; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (i == 3) ? 32'h0 : $urandom;
            if (i == 5) rb = 32'($urandom_range(1, 9));
            run_op(rop, ra, rb, 5'(i + 18), ref_res(rop, ra, rb), lat_of(rop, ra, rb), 1'b0);
        end

        chk("sb_empty", 32'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
